// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a registered 4-bit ALU: buffers tagged commands, issues one per cycle,
// tracks the two-stage in-flight pipeline and returns tagged results in order with backpressure.
module alu_cmd_sequencer #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_tag,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic [2:0] rsp_op,
    output logic [3:0] rsp_tag,
    output logic       busy
);
    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RSP_DEPTH);
    localparam logic [CAW:0]   CMD_FULL = (CAW + 1)'(CMD_DEPTH);
    localparam logic [RAW:0]   RSP_FULL = (RAW + 1)'(RSP_DEPTH);
    localparam logic [RAW+1:0] RSP_CREDIT = (RAW + 2)'(RSP_DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] tag;
    } cmd_t;

    typedef struct packed {
        logic [3:0] result;
        logic       carry;
        logic [2:0] op;
        logic [3:0] tag;
    } rsp_t;

    cmd_t           cmd_mem_q [CMD_DEPTH];
    cmd_t           cmd_mem_d [CMD_DEPTH];
    logic [CAW-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [CAW:0]   cmd_count_q, cmd_count_d;

    rsp_t           rsp_mem_q [RSP_DEPTH];
    rsp_t           rsp_mem_d [RSP_DEPTH];
    logic [RAW-1:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
    logic [RAW:0]   rsp_count_q, rsp_count_d;

    logic       init_q, init_d;
    logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [2:0] s1_op_q, s1_op_d, s2_op_q, s2_op_d;
    logic [3:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;

    logic           cmd_push, issue, rsp_push, rsp_pop;
    logic [RAW+1:0] credit_used;
    cmd_t           cmd_in, cmd_head;
    rsp_t           rsp_in, rsp_head;

    assign cmd_in   = {cmd_a, cmd_b, cmd_op, cmd_tag};
    assign cmd_head = cmd_mem_q[cmd_rptr_q];
    assign rsp_in   = {alu_result, alu_carry, s2_op_q, s2_tag_q};
    assign rsp_head = rsp_mem_q[rsp_rptr_q];

    // init_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = init_q && (cmd_count_q < CMD_FULL);
    assign cmd_push  = cmd_valid && cmd_ready;

    // Everything in flight has a reserved response slot, so capture can never overflow.
    assign credit_used = (RAW + 2)'(rsp_count_q) + (RAW + 2)'(s1_v_q) + (RAW + 2)'(s2_v_q);
    assign issue       = (cmd_count_q != '0) && (credit_used < RSP_CREDIT);

    assign rsp_valid = (rsp_count_q != '0);
    assign rsp_push  = s2_v_q;
    assign rsp_pop   = rsp_valid && rsp_ready;

    always_comb begin
        cmd_mem_d   = cmd_mem_q;
        cmd_wptr_d  = cmd_wptr_q;
        cmd_rptr_d  = cmd_rptr_q;
        cmd_count_d = cmd_count_q + (CAW + 1)'(cmd_push) - (CAW + 1)'(issue);
        rsp_mem_d   = rsp_mem_q;
        rsp_wptr_d  = rsp_wptr_q;
        rsp_rptr_d  = rsp_rptr_q;
        rsp_count_d = rsp_count_q + (RAW + 1)'(rsp_push) - (RAW + 1)'(rsp_pop);
        init_d      = 1'b1;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        s1_v_d      = 1'b0;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s2_v_d      = s1_v_q;
        s2_op_d     = s1_op_q;
        s2_tag_d    = s1_tag_q;

        if (cmd_push) begin
            cmd_mem_d[cmd_wptr_q] = cmd_in;
            cmd_wptr_d            = cmd_wptr_q + CAW'(1);
        end
        if (issue) begin
            cmd_rptr_d = cmd_rptr_q + CAW'(1);
            alu_a_d    = cmd_head.a;
            alu_b_d    = cmd_head.b;
            alu_op_d   = cmd_head.op;
            s1_v_d     = 1'b1;
            s1_op_d    = cmd_head.op;
            s1_tag_d   = cmd_head.tag;
        end
        if (rsp_push) begin
            rsp_mem_d[rsp_wptr_q] = rsp_in;
            rsp_wptr_d            = rsp_wptr_q + RAW'(1);
        end
        if (rsp_pop) begin
            rsp_rptr_d = rsp_rptr_q + RAW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            cmd_count_q <= '0;
            rsp_wptr_q  <= '0;
            rsp_rptr_q  <= '0;
            rsp_count_q <= '0;
            init_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            s1_v_q      <= 1'b0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_op_q     <= '0;
            s2_tag_q    <= '0;
        end else begin
            cmd_wptr_q  <= cmd_wptr_d;
            cmd_rptr_q  <= cmd_rptr_d;
            cmd_count_q <= cmd_count_d;
            rsp_wptr_q  <= rsp_wptr_d;
            rsp_rptr_q  <= rsp_rptr_d;
            rsp_count_q <= rsp_count_d;
            init_q      <= init_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            s1_v_q      <= s1_v_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s2_v_q      <= s2_v_d;
            s2_op_q     <= s2_op_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    // Storage only; validity is tracked by the reset pointers and counts.
    always_ff @(posedge clk) begin
        cmd_mem_q <= cmd_mem_d;
        rsp_mem_q <= rsp_mem_d;
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

    assign rsp_result = rsp_valid ? rsp_head.result : '0;
    assign rsp_carry  = rsp_valid ? rsp_head.carry : 1'b0;
    assign rsp_op     = rsp_valid ? rsp_head.op : '0;
    assign rsp_tag    = rsp_valid ? rsp_head.tag : '0;

    assign busy = (cmd_count_q != '0) || s1_v_q || s2_v_q || (rsp_count_q != '0);

    rsp_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_push && !rsp_pop && (rsp_count_q == RSP_FULL)));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural registered ALU attached.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b, cmd_tag;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready, rsp_carry, busy;
    logic [3:0] rsp_result, rsp_tag;
    logic [2:0] rsp_op;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    // Returns {carry, result}.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        int         ai, bi, s;
        logic [7:0] w;
        logic [3:0] r;
        logic       c;
        ai = int'(a);
        bi = int'(b);
        c  = 1'b0;
        r  = 4'h0;
        case (op)
            3'd0: begin s = ai + bi; r = 4'(s); c = (s > 15); end
            3'd1: begin r = 4'(ai - bi); c = (ai >= bi); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin w = {4'h0, a} << b[1:0]; r = w[3:0]; c = w[4]; end
            default: begin w = {a, 4'h0} >> b[1:0]; r = w[7:4]; c = w[3]; end
        endcase
        return {c, r};
    endfunction

    function automatic logic [11:0] ref_rsp(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] op, input logic [3:0] tag);
        logic [4:0] f;
        f = alu_fn(a, b, op);
        return {f[3:0], f[4], op, tag};
    endfunction

    always @(posedge clk) {alu_carry, alu_result} <= alu_fn(alu_a, alu_b, alu_op);

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    logic [11:0] exp_q[$];
    int          pop_cyc[$];
    bit          rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expectations enter at the accept handshake, leave at the response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) exp_q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op, cmd_tag));
            if (rsp_valid && rsp_ready) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
                else check("rsp_data", int'({rsp_result, rsp_carry, rsp_op, rsp_tag}),
                           int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] tag);
        bit got;
        got = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready;
            if (!got) stall_cnt++;
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [3:0] tag);
        send(4'($urandom), 4'($urandom), 3'($urandom), tag);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            step(1);
            n++;
        end
        check("drain_done", int'(exp_q.size() != 0 || busy), 0);
    endtask

    function automatic int pop_gaps();
        int bad;
        bad = 0;
        for (int i = 1; i < pop_cyc.size(); i++)
            if (pop_cyc[i] != pop_cyc[i-1] + 1) bad++;
        return bad;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b1;
        step(3);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_alu", int'({alu_a, alu_b, alu_op}), 0);
        check("rst_rsp_fields", int'({rsp_result, rsp_carry, rsp_op, rsp_tag}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", int'(cmd_ready), 0);
        step(1);
        check("ready_after_edge", int'(cmd_ready), 1);

        // ADD 9+8 latency
        send(4'd9, 4'd8, 3'd0, 4'd3);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step(1);
            n++;
        end
        check("add_latency", n, 3);
        check("add_result", int'({rsp_result, rsp_carry, rsp_op, rsp_tag}), 12'b0001_1_000_0011);
        drain();

        // SUB, LSL, LSR back-to-back
        pop_cyc.delete();
        send(4'd3, 4'd5, 3'd1, 4'd1);
        send(4'b0011, 4'b0010, 3'd6, 4'd2);
        send(4'b1000, 4'b0001, 3'd7, 4'd4);
        drain();
        check("b2b_count", pop_cyc.size(), 3);
        check("b2b_gaps", pop_gaps(), 0);

        // Full backpressure: 8 accepted, then cmd_ready low
        rsp_ready = 1'b0;
        stall_cnt = 0;
        for (int t = 0; t < 8; t++) send_rand(4'(t));
        step(4);
        check("bp_stalls", stall_cnt, 0);
        check("bp_cmd_ready", int'(cmd_ready), 0);
        check("bp_rsp_valid", int'(rsp_valid), 1);
        check("bp_head_tag", int'(rsp_tag), 0);
        check("bp_outstanding", exp_q.size(), 8);
        rsp_ready = 1'b1;
        drain();

        // Sustained stream
        pop_cyc.delete();
        stall_cnt = 0;
        for (int t = 0; t < 16; t++) send_rand(4'(t));
        drain();
        check("stream_stalls", stall_cnt, 0);
        check("stream_count", pop_cyc.size(), 16);
        check("stream_gaps", pop_gaps(), 0);

        // Reset with work queued, in flight and pending
        rsp_ready = 1'b0;
        for (int t = 0; t < 6; t++) send_rand(4'(t + 8));
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_rsp_valid", int'(rsp_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_alu", int'({alu_a, alu_b, alu_op}), 0);
        check("mid_rst_cmd_ready", int'(cmd_ready), 0);
        step(2);
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        pop_cyc.delete();
        send(4'd1, 4'd1, 3'd0, 4'd5);
        drain();
        check("post_rst_count", pop_cyc.size(), 1);

        // Random traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 200; t++) begin
                    send_rand(4'(t));
                    if ($urandom_range(0, 3) == 0) step(1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
